// File: rtl/maze_map_ctrl.sv
// rtl/maze_map_ctrl.sv - 20x15 maze tile map storage with render/query/edit port arbitration
//
// Optional feature macro: MAZE_MAP_EDIT_EN (edit port, w_ack and q/w round-robin).
// Without it the edit inputs are ignored, w_ack stays 0 and queries get every free cycle.
//
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   h_count, v_count    VGA timing counters
//   tile_bit            registered map bit of the tile under the current pixel
//   init_done           storage loaded from DEFAULT_MAP
//   q_req, q_x, q_y     collision query; q_ack pulse with q_hit
//   w_req, w_x, w_y,    map edit; w_ack pulse when committed
//   w_val
module maze_map_ctrl #(
    parameter logic [299:0] DEFAULT_MAP = 300'hFFFFF_80001_80001_80001_80001_80001_80001_80001_80001_80001_80001_80001_80001_80001_FFFFF,
    parameter int H_ACT_START = 144,
    parameter int V_ACT_START = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    output logic       tile_bit,
    output logic       init_done,
    input  logic       q_req,
    input  logic [4:0] q_x,
    input  logic [3:0] q_y,
    output logic       q_ack,
    output logic       q_hit,
    input  logic       w_req,
    input  logic [4:0] w_x,
    input  logic [3:0] w_y,
    input  logic       w_val,
    output logic       w_ack
);
`ifdef MAZE_MAP_EDIT_EN
    localparam bit EDIT_EN = 1'b1;
`else
    localparam bit EDIT_EN = 1'b0;
`endif

    localparam int MAP_W = 20;
    localparam int MAP_H = 15;
    localparam int TILES = MAP_W * MAP_H;

    // Fetch two pixels ahead of each tile column: one cycle for the
    // synchronous read, one for the tile_bit register.
    localparam logic [9:0] H_FETCH_FIRST = 10'(H_ACT_START - 2);
    localparam logic [9:0] H_FETCH_LAST  = 10'(H_ACT_START - 2 + 32 * (MAP_W - 1));
    // tile_bit is registered, so the hold window is one pixel ahead of the
    // active area: it is 0 on the first pixel outside.
    localparam logic [9:0] H_KEEP_FIRST  = 10'(H_ACT_START - 1);
    localparam logic [9:0] H_KEEP_LAST   = 10'(H_ACT_START + 32 * MAP_W - 2);
    localparam logic [9:0] V_FIRST       = 10'(V_ACT_START);
    localparam logic [9:0] V_LAST        = 10'(V_ACT_START + 32 * MAP_H - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t     state, state_n;
    logic [8:0] init_cnt;
    logic       mem [0:TILES-1];
    logic       rd_q;

    logic [8:0] port_addr;
    logic       port_we;
    logic       port_wdata;

    logic       render_rd, render_d1;
    logic       q_rd_d1;
    logic       q_busy, w_busy;
    logic       prio_w;
    logic       grant_q, grant_w;

    logic       v_in_map;
    logic       render_slot;
    logic [3:0] render_row;
    logic [4:0] render_col;
    logic [8:0] render_addr;
    logic       keep_win;

    logic       q_pend, w_pend;
    logic       q_in_range, w_in_range;
    logic [8:0] q_addr, w_addr;

    assign v_in_map    = (v_count >= V_FIRST) && (v_count <= V_LAST);
    assign render_row  = 4'((v_count - V_FIRST) >> 5);
    assign render_col  = 5'((h_count - H_FETCH_FIRST) >> 5);
    assign render_slot = (state == ST_RUN) && v_in_map
                         && (h_count >= H_FETCH_FIRST) && (h_count <= H_FETCH_LAST)
                         && (5'(h_count - H_FETCH_FIRST) == 5'd0);
    assign render_addr = 9'(render_row) * 9'd20 + 9'(render_col);
    assign keep_win    = (state == ST_RUN) && v_in_map
                         && (h_count >= H_KEEP_FIRST) && (h_count <= H_KEEP_LAST);

    assign q_in_range = (q_x < 5'd20) && (q_y < 4'd15);
    assign q_addr     = 9'(q_y) * 9'd20 + 9'(q_x);
    assign w_in_range = (w_x < 5'd20) && (w_y < 4'd15);
    assign w_addr     = 9'(w_y) * 9'd20 + 9'(w_x);

    // A request already granted stays masked until its ack cycle has passed.
    assign q_pend = q_req && !q_busy;
    assign w_pend = EDIT_EN && w_req && !w_busy;

    always_comb begin
        state_n    = state;
        port_addr  = '0;
        port_we    = 1'b0;
        port_wdata = 1'b0;
        render_rd  = 1'b0;
        grant_q    = 1'b0;
        grant_w    = 1'b0;
        case (state)
            ST_INIT: begin
                port_addr  = init_cnt;
                port_we    = 1'b1;
                port_wdata = DEFAULT_MAP[init_cnt];
                if (init_cnt == 9'(TILES - 1)) begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                if (render_slot) begin
                    port_addr = render_addr;
                    render_rd = 1'b1;
                end else begin
                    if (q_pend && (!w_pend || !prio_w)) begin
                        grant_q = 1'b1;
                    end else if (w_pend) begin
                        grant_w = 1'b1;
                    end
                    if (grant_q && q_in_range) begin
                        port_addr = q_addr;
                    end
                    if (grant_w && w_in_range) begin
                        port_addr  = w_addr;
                        port_we    = 1'b1;
                        port_wdata = w_val;
                    end
                end
            end
        endcase
    end

    // Single-port storage, synchronous read; not reset, the loader refills it.
    always_ff @(posedge clk) begin
        if (port_we) begin
            mem[port_addr] <= port_wdata;
        end
        rd_q <= mem[port_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            render_d1 <= 1'b0;
            q_rd_d1   <= 1'b0;
            q_busy    <= 1'b0;
            w_busy    <= 1'b0;
            prio_w    <= 1'b0;
            tile_bit  <= 1'b0;
            q_ack     <= 1'b0;
            q_hit     <= 1'b0;
            w_ack     <= 1'b0;
        end else begin
            state     <= state_n;
            init_done <= (state_n == ST_RUN);
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 9'd1;
            end
            render_d1 <= render_rd;
            q_rd_d1   <= grant_q && q_in_range;
            // Out-of-range queries skip the port and report a wall directly.
            q_ack     <= q_rd_d1 || (grant_q && !q_in_range);
            q_hit     <= q_rd_d1 ? rd_q : (grant_q && !q_in_range);
            w_ack     <= grant_w;
            q_busy    <= grant_q || (q_busy && !q_ack);
            w_busy    <= grant_w || (w_busy && !w_ack);
            if (grant_q) begin
                prio_w <= 1'b1;
            end else if (grant_w) begin
                prio_w <= 1'b0;
            end
            if (!keep_win) begin
                tile_bit <= 1'b0;
            end else if (render_d1) begin
                tile_bit <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_maze_map_ctrl.sv
// tb/tb_maze_map_ctrl.sv - directed self-checking bench for maze_map_ctrl
module tb_maze_map_ctrl;
    function automatic logic [299:0] build_map();
        logic [299:0] m;
        m = '0;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                m[r * 20 + c] = (r == 0) || (r == 14) || (c == 0) || (c == 19) || (((r + c) % 3) == 0);
            end
        end
        return m;
    endfunction

    localparam logic [299:0] MAP = build_map();

    logic       clk;
    logic       rst_n;
    logic [9:0] h_count, v_count;
    logic       tile_bit, init_done;
    logic       q_req, q_ack, q_hit;
    logic [4:0] q_x, w_x;
    logic [3:0] q_y, w_y;
    logic       w_req, w_val, w_ack;

    logic [299:0] map_v;
    logic         h_auto;
    int           n_checks = 0;
    int           n_fail   = 0;

    maze_map_ctrl #(.DEFAULT_MAP(MAP), .H_ACT_START(144), .V_ACT_START(31)) dut (
        .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
        .tile_bit(tile_bit), .init_done(init_done),
        .q_req(q_req), .q_x(q_x), .q_y(q_y), .q_ack(q_ack), .q_hit(q_hit),
        .w_req(w_req), .w_x(w_x), .w_y(w_y), .w_val(w_val), .w_ack(w_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (h_auto) h_count = h_count + 10'd1;
    endtask

    task automatic wait_init(input string tag);
        int   n;
        logic bad;
        n = 0;
        bad = 1'b0;
        while (!init_done && n < 400) begin
            tick();
            n++;
            bad = bad | q_ack | w_ack | tile_bit | q_hit;
        end
        check_val({tag, "_len"}, n, 300);
        check_val({tag, "_quiet"}, bad, 0);
    endtask

    task automatic do_query(input int x, input int y, input logic exp_hit, input int exp_lat, input string tag);
        int n;
        q_x = 5'(x);
        q_y = 4'(y);
        q_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!q_ack && n < 20);
        check_val({tag, "_lat"}, n, exp_lat);
        check_val({tag, "_hit"}, q_hit, exp_hit);
        q_req = 1'b0;
        tick();
    endtask

    task automatic do_edit(input int x, input int y, input logic val, input string tag);
        int n;
        w_x = 5'(x);
        w_y = 4'(y);
        w_val = val;
        w_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!w_ack && n < 20);
        check_val({tag, "_lat"}, n, 1);
        w_req = 1'b0;
        tick();
    endtask

    task automatic scan_line(input int v, input int r);
        v_count = 10'(v);
        for (int h = 140; h <= 790; h++) begin
            h_count = 10'(h);
            if (h == 143 || h == 784) begin
                check_val($sformatf("edge_v%0d_h%0d", v, h), tile_bit, 0);
            end else if (h >= 144 && h <= 752 && ((h - 144) % 32) == 0) begin
                if (r >= 0) begin
                    check_val($sformatf("tile_r%0d_c%0d", r, (h - 144) / 32), tile_bit, map_v[r * 20 + (h - 144) / 32]);
                end else begin
                    check_val($sformatf("offmap_v%0d_h%0d", v, h), tile_bit, 0);
                end
            end
            tick();
        end
    endtask

    initial begin
        int n;
        logic acc;
        logic [8:0] qm, wm;
        logic exp_edited;

        map_v   = MAP;
        h_auto  = 1'b0;
        rst_n   = 1'b0;
        h_count = '0;
        v_count = '0;
        q_req   = 1'b1;
        q_x     = 5'd1;
        q_y     = 4'd0;
        w_req   = 1'b0;
        w_x     = '0;
        w_y     = '0;
        w_val   = 1'b0;
        repeat (3) tick();
        check_val("rst_tile_bit", tile_bit, 0);
        check_val("rst_q_ack", q_ack, 0);
        check_val("rst_q_hit", q_hit, 0);
        check_val("rst_w_ack", w_ack, 0);
        check_val("rst_init_done", init_done, 0);

        // Query held through INIT is served right after init_done.
        rst_n = 1'b1;
        wait_init("init");
        tick();
        check_val("init_q_ack_early", q_ack, 0);
        tick();
        check_val("init_q_ack", q_ack, 1);
        check_val("init_q_hit", q_hit, 1);
        q_req = 1'b0;
        tick();

        scan_line(30, -1);
        for (int r = 0; r < 15; r++) scan_line(31 + 32 * r, r);
        scan_line(511, -1);

        h_count = '0;
        v_count = '0;
        tick();
        do_query(1, 0, 1'b1, 2, "q_1_0");
        do_query(1, 1, 1'b0, 2, "q_1_1");
        do_query(20, 3, 1'b1, 1, "q_20_3");
        do_query(4, 15, 1'b1, 1, "q_4_15");

        // Query raised on a render slot waits one cycle; tile_bit unaffected.
        h_auto  = 1'b1;
        v_count = 10'd255;
        h_count = 10'd140;
        tick();
        tick();
        q_x = 5'd1;
        q_y = 4'd0;
        q_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!q_ack && n < 20);
        check_val("q_on_slot_lat", n, 3);
        check_val("q_on_slot_hit", q_hit, 1);
        check_val("q_on_slot_tile", tile_bit, map_v[140]);
        q_req  = 1'b0;
        h_auto = 1'b0;
        h_count = '0;
        v_count = '0;
        tick();

`ifdef MAZE_MAP_EDIT_EN
        do_edit(5, 7, 1'b0, "w_5_7");
        do_query(5, 7, 1'b0, 2, "q_5_7_edited");
        exp_edited = 1'b0;
`else
        w_x = 5'd5;
        w_y = 4'd7;
        w_val = 1'b0;
        w_req = 1'b1;
        acc = 1'b0;
        repeat (5) begin
            tick();
            acc = acc | w_ack;
        end
        check_val("w_ignored_ack", acc, 0);
        w_req = 1'b0;
        tick();
        do_query(5, 7, 1'b1, 2, "q_5_7_readonly");
        exp_edited = 1'b1;
`endif

        v_count = 10'd255;
        for (int h = 140; h <= 306; h++) begin
            h_count = 10'(h);
            if (h == 144) check_val("v255_h144", tile_bit, map_v[140]);
            if (h == 304) check_val("v255_h304", tile_bit, exp_edited);
            tick();
        end
        h_count = '0;
        v_count = '0;
        tick();

`ifdef MAZE_MAP_EDIT_EN
        // Both held: grants q,w,idle,q,w,... so both acks land every third cycle.
        q_x = 5'd1;
        q_y = 4'd0;
        w_x = 5'd20;
        w_y = 4'd0;
        w_val = 1'b0;
        q_req = 1'b1;
        w_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            qm[i] = q_ack;
            wm[i] = w_ack;
            tick();
        end
        q_req = 1'b0;
        w_req = 1'b0;
        tick();
        tick();
        check_val("rr_q_acks", qm, 9'b100100100);
        check_val("rr_w_acks", wm, 9'b100100100);
        do_query(0, 1, 1'b1, 2, "q_0_1_after_oor_edit");
`else
        qm = '0;
        wm = '0;
`endif

        // Reset while a query is in flight: no ack, map reloaded.
        q_x = 5'd5;
        q_y = 4'd7;
        q_req = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        check_val("midrst_q_ack", q_ack, 0);
        check_val("midrst_init_done", init_done, 0);
        q_req = 1'b0;
        rst_n = 1'b1;
        wait_init("reinit");
        tick();
        do_query(5, 7, 1'b1, 2, "q_5_7_reloaded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/maze_map_ctrl.md
# maze_map_ctrl

Owner and sequencer of the 20x15 maze tile map: holds the map in single-port 300x1 storage and arbitrates that one port between the VGA background renderer, player collision queries and map edits (e.g. clearing a picked-up flower tile). After reset it initialises storage from a default map, then serves the renderer at fixed pixel slots and the other requesters round-robin in the remaining cycles. It sits between the VGA timing counters, the background colour mux and the player/game logic.

## Interface
- DEFAULT_MAP, 300-bit maze constant (row-major, bit 0 = row 0 col 0, 1 = wall/flower), power-on map contents
- H_ACT_START, 144, first active h_count; V_ACT_START, 31, first active v_count
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- h_count  in  10  VGA horizontal counter
- v_count  in  10  VGA vertical counter
- tile_bit  out  1  map bit of the tile under the current pixel, registered
- init_done  out  1  high once storage is loaded
- q_req  in  1  collision query request; q_x in 5, q_y in 4 tile coordinates
- q_ack  out  1  one-cycle pulse, query done; q_hit out 1 map bit, valid with q_ack
- w_req  in  1  edit request; w_x in 5, w_y in 4, w_val in 1 value to store
- w_ack  out  1  one-cycle pulse, edit committed

## Operation
- Address = y*20 + x, 9 bits; storage reads are synchronous (data one cycle after address).
- FSM INIT: write DEFAULT_MAP[a] to address a, a = 0..299, one per cycle; port owned by loader; tile_bit, q_ack, w_ack held 0; requests pending, not lost. After a = 299 -> RUN, init_done = 1.
- RUN, render slot: v_count in [31,510] and h_count = 142 + 32*c, c = 0..19; port reads address row*20 + c, row = (v_count-31)/32. Render slots have absolute priority.
- RUN, other cycles: grant q or w; both pending -> the one not granted last; reset pointer favours query.
- Query x>=20 or y>=15: no port use, q_hit = 1 (treated as wall). Edit out of range: acked, storage unchanged.
- Requester holds req and operands stable until ack; ack is a single-cycle pulse; req still high the cycle after ack is a new request.
- Edit and render read never overlap; render sees edited bit from the next fetch of that tile.

## Timing
- Reset values: tile_bit 0, q_ack 0, q_hit 0, w_ack 0, init_done 0, state INIT, pointer = query.
- Reset mid-operation (any state): next cycle all above reset values, in-flight grant dropped, reload restarts at a = 0. Storage reload is complete 300 cycles after rst_n release.
- Render: fetch at h = 142+32c -> tile_bit valid for h = 144+32c .. 175+32c; outside active area tile_bit = 0 from the next cycle.
- Query: granted cycle t -> q_ack, q_hit at t+2 (address, read, register). Out-of-range query acked at t+1.
- Edit: granted cycle t -> write at t, w_ack at t+1.
- Max wait for a lone requester: 2 cycles plus any render slot; one pending query plus edit both served within 6 non-render cycles.

## Configuration
- MAZE_MAP_EDIT_EN defined: write port, w_ack and round-robin active as above.
- Undefined: w_req/w_x/w_y/w_val ignored, w_ack tied 0, storage read-only after INIT, queries granted every free cycle.

## Test plan
- Reset, release rst_n -> init_done rises exactly 300 cycles later; all outputs 0 meanwhile; q_req held during INIT acked only after init_done.
- Full frame scan with DEFAULT_MAP -> tile_bit at (h=144+32c, v=31+32r) equals DEFAULT_MAP[r*20+c] for all 300 tiles; 0 at h=143, 784, v=30, 511.
- Query (x=1, y=0) with map bit 1 in a non-render cycle -> q_ack, q_hit=1 two cycles later; query (x=20, y=3) -> q_hit=1 one cycle later.
- Edit (x=5,y=7,val=0) then query same tile -> w_ack next cycle, later q_hit=0; next frame tile_bit 0 at h=304, v=255.
- q_req and w_req raised together, held, repeated -> grants alternate q,w,q,w; any request landing on h=142+32c delayed one cycle, render tile_bit unaffected.
- Assert rst_n=0 one cycle during a pending query and after an edit -> no ack issued, reload restores DEFAULT_MAP bit of edited tile.
